// File: rtl/cvm300_pixel_packer_if.sv
// ============================================================================
//  Module      : cvm300_pixel_packer_if
//  Description : Sensor-side pixel bus, FIFO write side and capture status
//                bundle for cvm300_pixel_packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cvm300_pixel_packer_if;
    logic        arm;
    logic [9:0]  CVM300_D;
    logic        CVM300_Data_valid;
    logic        CVM300_Line_valid;
    logic        fifo_full;
    logic [31:0] fifo_din;
    logic        fifo_wr_en;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic        line_error;
    logic [18:0] pixel_count;

    // Master drives the sensor bus, arm request and FIFO status.
    modport master (
        output arm, CVM300_D, CVM300_Data_valid, CVM300_Line_valid, fifo_full,
        input  fifo_din, fifo_wr_en, busy, frame_done, overflow, line_error, pixel_count
    );

    // Slave is the packer itself.
    modport slave (
        input  arm, CVM300_D, CVM300_Data_valid, CVM300_Line_valid, fifo_full,
        output fifo_din, fifo_wr_en, busy, frame_done, overflow, line_error, pixel_count
    );
endinterface

`default_nettype wire

// File: rtl/cvm300_pixel_packer.sv
// ============================================================================
//  Module      : cvm300_pixel_packer
//  Description : Captures one CVM300 frame per arm request, truncates pixels
//                to 8 bits, packs four per 32-bit FIFO word, and reports
//                overflow / short-line / frame-complete status.
//                Optional macro PACKER_TEST_PATTERN_EN replaces pixel data
//                with a pixel_count ramp.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cvm300_pixel_packer #(
    parameter int FRAME_PIXELS = 316224,
    parameter int LINE_PIXELS  = 648
) (
    input  wire logic             CVM300_CLK_OUT,
    input  wire logic             write_reset,
    cvm300_pixel_packer_if.slave  bus
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ARMED   = 2'd1;
    localparam logic [1:0] c_CAPTURE = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    localparam logic [18:0] c_FRAME = 19'(FRAME_PIXELS);
    localparam logic [9:0]  c_LINE  = 10'(LINE_PIXELS);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        w_busy;

    logic        r_arm_d;
    logic        r_lval_d;
    logic [23:0] r_pack;
    logic [18:0] r_pixel_count;
    logic [9:0]  r_line_count;
    logic [31:0] r_fifo_din;
    logic        r_fifo_wr_en;
    logic        r_frame_done;
    logic        r_overflow;
    logic        r_line_error;

    logic        w_arm_rise;
    logic        w_start;
    logic        w_accept;
    logic        w_frame_end;
    logic        w_line_bad;
    logic [1:0]  w_lane;
    logic [7:0]  w_byte;
    logic        w_unused_d;

    assign w_arm_rise  = bus.arm & ~r_arm_d;
    assign w_start     = (r_state == c_IDLE) & w_arm_rise;
    // Accepting stops once the frame is full, so pixel_count saturates.
    assign w_accept    = (r_state == c_CAPTURE) & bus.CVM300_Data_valid
                       & bus.CVM300_Line_valid & (r_pixel_count < c_FRAME);
    assign w_frame_end = (r_state == c_CAPTURE) & (r_pixel_count == c_FRAME);
    assign w_lane      = r_pixel_count[1:0];
    // Falling LVAL during capture closes a line; flag it if its length is off.
    assign w_line_bad  = (r_state == c_CAPTURE) & ~bus.CVM300_Line_valid & r_lval_d
                       & (r_line_count != c_LINE);

`ifdef PACKER_TEST_PATTERN_EN
    assign w_byte     = r_pixel_count[7:0];
    assign w_unused_d = ^bus.CVM300_D;
`else
    assign w_byte     = bus.CVM300_D[9:2];
    assign w_unused_d = ^bus.CVM300_D[1:0];
`endif

    // State register.
    always_ff @(posedge CVM300_CLK_OUT) begin
        if (write_reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: arm edge starts, LVAL low syncs to a line boundary.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:    if (w_arm_rise)              w_next_state = c_ARMED;
            c_ARMED:   if (!bus.CVM300_Line_valid)  w_next_state = c_CAPTURE;
            c_CAPTURE: if (r_pixel_count == c_FRAME) w_next_state = c_DONE;
            c_DONE:    w_next_state = c_IDLE;
            default:   w_next_state = c_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_busy = 1'b0;
        if ((r_state == c_ARMED) || (r_state == c_CAPTURE)) begin
            w_busy = 1'b1;
        end
    end

    // Edge-detect history for arm and LVAL.
    always_ff @(posedge CVM300_CLK_OUT) begin
        if (write_reset) begin
            r_arm_d  <= 1'b0;
            r_lval_d <= 1'b0;
        end else begin
            r_arm_d  <= bus.arm;
            r_lval_d <= bus.CVM300_Line_valid;
        end
    end

    // Per-line DVAL counter, restarted on every LVAL rising edge.
    always_ff @(posedge CVM300_CLK_OUT) begin
        if (write_reset) begin
            r_line_count <= 10'd0;
        end else if ((r_state == c_CAPTURE) && bus.CVM300_Line_valid) begin
            if (!r_lval_d) begin
                r_line_count <= bus.CVM300_Data_valid ? 10'd1 : 10'd0;
            end else if (bus.CVM300_Data_valid) begin
                r_line_count <= r_line_count + 10'd1;
            end
        end
    end

    // Pixel packing, FIFO write strobe, pixel count and sticky status flags.
    always_ff @(posedge CVM300_CLK_OUT) begin
        if (write_reset) begin
            r_pack        <= 24'd0;
            r_pixel_count <= 19'd0;
            r_fifo_din    <= 32'd0;
            r_fifo_wr_en  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overflow    <= 1'b0;
            r_line_error  <= 1'b0;
        end else begin
            r_fifo_wr_en <= 1'b0;
            if (w_start) begin
                r_pack        <= 24'd0;
                r_pixel_count <= 19'd0;
                r_frame_done  <= 1'b0;
                r_overflow    <= 1'b0;
                r_line_error  <= 1'b0;
            end
            if (w_accept) begin
                r_pixel_count <= r_pixel_count + 19'd1;
                case (w_lane)
                    2'd0: r_pack[7:0]   <= w_byte;
                    2'd1: r_pack[15:8]  <= w_byte;
                    2'd2: r_pack[23:16] <= w_byte;
                    default: begin
                        // Lane 3 completes the word; a full FIFO drops it.
                        r_fifo_din <= {w_byte, r_pack};
                        if (bus.fifo_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_fifo_wr_en <= 1'b1;
                        end
                    end
                endcase
            end
            if (w_line_bad) begin
                r_line_error <= 1'b1;
            end
            if (w_frame_end) begin
                r_frame_done <= 1'b1;
            end
        end
    end

    assign bus.fifo_din    = r_fifo_din;
    assign bus.fifo_wr_en  = r_fifo_wr_en;
    assign bus.busy        = w_busy;
    assign bus.frame_done  = r_frame_done;
    assign bus.overflow    = r_overflow;
    assign bus.line_error  = r_line_error;
    assign bus.pixel_count = r_pixel_count;

endmodule

`default_nettype wire

// File: tb/tb_cvm300_pixel_packer.sv
// ============================================================================
//  Module      : tb_cvm300_pixel_packer
//  Description : Self-checking bench for cvm300_pixel_packer with an 8-pixel
//                frame of two 4-pixel lines.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cvm300_pixel_packer;

    logic clk = 1'b0;
    logic rst;

    cvm300_pixel_packer_if bus();

    cvm300_pixel_packer #(
        .FRAME_PIXELS (8),
        .LINE_PIXELS  (4)
    ) dut (
        .CVM300_CLK_OUT (clk),
        .write_reset    (rst),
        .bus            (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0][9:0] px;
        logic [31:0]     exp0;
        logic [31:0]     exp1;
    } vec_t;

    vec_t        vecs [3];
    logic [31:0] wq [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // Collect every FIFO write between clock edges.
    always @(negedge clk) begin
        if (bus.fifo_wr_en === 1'b1) wq.push_back(bus.fifo_din);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // In pattern mode every frame carries the same count ramp.
    function automatic logic [31:0] exp_w(input logic [31:0] hand, input int idx);
`ifdef PACKER_TEST_PATTERN_EN
        return (idx == 0) ? 32'h03020100 : 32'h07060504;
`else
        return hand;
`endif
    endfunction

    function automatic logic [31:0] wq_at(input int idx);
        return (wq.size() > idx) ? wq[idx] : 32'hDEADBEEF;
    endfunction

    task automatic arm_capture();
        wq.delete();
        bus.arm = 1'b1;
        tick();
        chk("busy_after_arm", bus.busy, 1);
        bus.arm = 1'b0;
        tick();
    endtask

    task automatic send_line(input logic [7:0][9:0] px, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            bus.CVM300_D          = px[i];
            bus.CVM300_Data_valid = 1'b1;
            bus.CVM300_Line_valid = 1'b1;
            tick();
        end
        bus.CVM300_Data_valid = 1'b0;
        bus.CVM300_Line_valid = 1'b0;
    endtask

    task automatic run_vec(input int v);
        arm_capture();
        chk("count_cleared", bus.pixel_count, 0);
        send_line(vecs[v].px, 0, 4);
        idle(2);
        send_line(vecs[v].px, 4, 4);
        chk("wr_en_last_word", bus.fifo_wr_en, 1);
        chk("done_not_early", bus.frame_done, 0);
        tick();
        chk("frame_done", bus.frame_done, 1);
        chk("busy_drop", bus.busy, 0);
        chk("pixel_count", bus.pixel_count, 8);
        chk("no_overflow", bus.overflow, 0);
        chk("no_line_error", bus.line_error, 0);
        chk("write_count", wq.size(), 2);
        chk("word0", wq_at(0), exp_w(vecs[v].exp0, 0));
        chk("word1", wq_at(1), exp_w(vecs[v].exp1, 1));
        idle(2);
    endtask

    logic [7:0][9:0] px_le;
    logic [7:0][9:0] px_seq;

    initial begin
        vecs[0].px   = {10'h010, 10'h00C, 10'h008, 10'h004, 10'h010, 10'h00C, 10'h008, 10'h004};
        vecs[0].exp0 = 32'h04030201;
        vecs[0].exp1 = 32'h04030201;
        vecs[1].px   = {10'h201, 10'h100, 10'h003, 10'h3FC, 10'h155, 10'h2AB, 10'h000, 10'h3FF};
        vecs[1].exp0 = 32'h55AA00FF;
        vecs[1].exp1 = 32'h804000FF;
        vecs[2].px   = {10'h002, 10'h001, 10'h300, 10'h200, 10'h07C, 10'h3F8, 10'h020, 10'h01C};
        vecs[2].exp0 = 32'h1FFE0807;
        vecs[2].exp1 = 32'h0000C080;
        px_le  = {10'h220, 10'h1DC, 10'h198, 10'h154, 10'h110, 10'h0CC, 10'h088, 10'h044};
        px_seq = {10'h020, 10'h01C, 10'h018, 10'h014, 10'h010, 10'h00C, 10'h008, 10'h004};

        rst                   = 1'b1;
        bus.arm               = 1'b0;
        bus.CVM300_D          = 10'd0;
        bus.CVM300_Data_valid = 1'b0;
        bus.CVM300_Line_valid = 1'b0;
        bus.fifo_full         = 1'b0;
        idle(3);
        rst = 1'b0;
        chk("rst_fifo_din", bus.fifo_din, 0);
        chk("rst_wr_en", bus.fifo_wr_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_line_error", bus.line_error, 0);
        chk("rst_pixel_count", bus.pixel_count, 0);
        idle(2);

        for (int v = 0; v < 3; v++) run_vec(v);

        // FIFO full across the second word: it is dropped, overflow latches.
        arm_capture();
        send_line(vecs[0].px, 0, 4);
        idle(2);
        bus.fifo_full = 1'b1;
        send_line(vecs[0].px, 4, 4);
        chk("ovf_no_strobe", bus.fifo_wr_en, 0);
        tick();
        bus.fifo_full = 1'b0;
        chk("ovf_frame_done", bus.frame_done, 1);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_write_count", wq.size(), 1);
        chk("ovf_word0", wq_at(0), exp_w(32'h04030201, 0));
        idle(2);

        // Short line of 3 pixels, then capture continues to a full frame.
        arm_capture();
        send_line(px_le, 0, 3);
        tick();
        chk("le_flag", bus.line_error, 1);
        chk("le_count3", bus.pixel_count, 3);
        idle(1);
        send_line(px_le, 3, 4);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            bus.CVM300_D          = px_le[7];
            bus.CVM300_Data_valid = 1'b1;
            bus.CVM300_Line_valid = 1'b1;
            tick();
        end
        bus.CVM300_Data_valid = 1'b0;
        bus.CVM300_Line_valid = 1'b0;
        idle(3);
        chk("le_saturated", bus.pixel_count, 8);
        chk("le_frame_done", bus.frame_done, 1);
        chk("le_sticky", bus.line_error, 1);
        chk("le_write_count", wq.size(), 2);
        chk("le_word0", wq_at(0), exp_w(32'h44332211, 0));
        chk("le_word1", wq_at(1), exp_w(32'h88776655, 1));
        idle(2);

        // Arm mid-line: that line is skipped; a mid-capture arm edge is ignored.
        wq.delete();
        bus.CVM300_D          = 10'h3FF;
        bus.CVM300_Data_valid = 1'b1;
        bus.CVM300_Line_valid = 1'b1;
        tick();
        bus.arm = 1'b1;
        tick();
        chk("mid_busy", bus.busy, 1);
        bus.arm = 1'b0;
        idle(2);
        chk("mid_no_accept", bus.pixel_count, 0);
        bus.CVM300_Data_valid = 1'b0;
        bus.CVM300_Line_valid = 1'b0;
        tick();
        send_line(px_seq, 0, 4);
        bus.arm = 1'b1;
        idle(2);
        bus.arm = 1'b0;
        chk("mid_arm_ignored", bus.pixel_count, 4);
        send_line(px_seq, 4, 4);
        tick();
        chk("mid_frame_done", bus.frame_done, 1);
        chk("mid_write_count", wq.size(), 2);
        chk("mid_word0", wq_at(0), exp_w(32'h04030201, 0));
        chk("mid_word1", wq_at(1), exp_w(32'h08070605, 1));
        idle(2);

        // Reset after 6 pixels: partial word discarded, outputs back to reset.
        arm_capture();
        for (int i = 0; i < 6; i++) begin
            bus.CVM300_D          = vecs[0].px[i];
            bus.CVM300_Data_valid = 1'b1;
            bus.CVM300_Line_valid = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wr_rst_fifo_din", bus.fifo_din, 0);
        chk("wr_rst_wr_en", bus.fifo_wr_en, 0);
        chk("wr_rst_busy", bus.busy, 0);
        chk("wr_rst_frame_done", bus.frame_done, 0);
        chk("wr_rst_overflow", bus.overflow, 0);
        chk("wr_rst_line_error", bus.line_error, 0);
        chk("wr_rst_pixel_count", bus.pixel_count, 0);
        idle(6);
        bus.CVM300_Data_valid = 1'b0;
        bus.CVM300_Line_valid = 1'b0;
        idle(2);
        chk("wr_rst_writes", wq.size(), 1);
        chk("wr_rst_idle_count", bus.pixel_count, 0);
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cvm300_pixel_packer.md
# cvm300_pixel_packer

Capture stage between the CVM300 parallel pixel bus and the image FIFO feeding the BTPipe readout. It runs in the sensor output clock domain and accepts one frame per arm request. Each 10-bit pixel is truncated to 8 bits, and four pixels are packed into one 32-bit FIFO word. It counts pixels and lines, and flags overflow or a short frame so software can discard a bad capture.

## Interface
Parameters:
- FRAME_PIXELS, 316224: pixels per frame (648×488); must be a multiple of 4.
- LINE_PIXELS, 648: pixels per line; used only for the line-length check.

Ports:
- CVM300_CLK_OUT in 1: sole clock; all logic on rising edge.
- write_reset in 1: synchronous, active-high reset.
- arm in 1: level; rising edge (registered internally) in IDLE starts a capture.
- CVM300_D in 10: pixel data; bits [9:2] are used.
- CVM300_Data_valid in 1: DVAL, pixel qualifier.
- CVM300_Line_valid in 1: LVAL, line qualifier.
- fifo_full in 1: FIFO full flag, write side.
- fifo_din out 32: packed word; pixel n at bits [8(n mod 4)+7 : 8(n mod 4)].
- fifo_wr_en out 1: one-cycle write strobe.
- busy out 1: high in ARMED/CAPTURE.
- frame_done out 1: sticky; set on a complete frame, cleared on arm edge.
- overflow out 1: sticky; set when a word is dropped because fifo_full was high.
- line_error out 1: sticky; set when a line's DVAL count ≠ LINE_PIXELS.
- pixel_count out 19: pixels accepted in the current or last frame.

## Operation
- States: IDLE → ARMED → CAPTURE → DONE → IDLE.
- IDLE: outputs quiet. An arm rising edge clears the sticky flags, pixel_count and the pack lane, then moves to ARMED.
- ARMED: waits for LVAL low, then moves to CAPTURE. This avoids starting mid-line.
- CAPTURE: each cycle with DVAL=1 and LVAL=1 accepts one pixel.
  - Writes D[9:2] into lane pixel_count[1:0] of the pack register and increments pixel_count.
  - On lane 3, the assembled word is registered to fifo_din with fifo_wr_en=1 next cycle.
  - If fifo_full=1 in the cycle the word would be written, fifo_wr_en stays 0, overflow sets and the word is lost. Capture continues.
- Line check: per-line pixel counter (10 bits) resets on LVAL rising edge. On LVAL falling edge, if count ≠ LINE_PIXELS, line_error sets.
- DVAL while LVAL=0 is ignored.
- Completion: when pixel_count reaches FRAME_PIXELS, go to DONE. Further DVAL is ignored.
- DONE: sets frame_done for good, returns to IDLE next cycle.
- An arm edge outside IDLE is ignored; arm has no effect mid-capture.
- Reset mid-operation returns to IDLE within one cycle. Any partial word is discarded and never written.

## Timing
- Reset values:
  - fifo_din=0, fifo_wr_en=0, busy=0
  - frame_done=0, overflow=0, line_error=0, pixel_count=0
  - state IDLE
- arm edge detect: 1 cycle from arm high to ARMED (busy=1 one cycle after arm is sampled high).
- Latency: fifo_wr_en asserts exactly 1 cycle after the cycle that accepted the 4th pixel of a word. Maximum write rate is one word per 4 clocks.
- fifo_full is sampled in the same cycle fifo_wr_en would be driven (registered path). The FIFO's programmed full threshold covers the 1-word slack.
- frame_done asserts 1 cycle after the final pixel's word write strobe; busy drops in the same cycle.
- pixel_count is 19 bits unsigned and saturates at FRAME_PIXELS; it never wraps.

## Configuration
- PACKER_TEST_PATTERN_EN defined: the pixel byte is replaced by pixel_count[7:0], giving a known ramp (word 0 = 32'h03020100). DVAL/LVAL timing, counting and flags are unchanged.
- Not defined: the byte is CVM300_D[9:2]; no pattern logic is synthesised.

## Test plan
- Reset, then arm with FRAME_PIXELS=8, LINE_PIXELS=4, two 4-pixel lines D = {10'h004,10'h008,10'h00C,10'h010} ×2 → two writes of 32'h04030201; frame_done=1; pixel_count=8; no errors.
- Same frame with fifo_full=1 during the 2nd word → only one write; overflow=1; frame_done=1.
- Line of 3 DVAL pixels with LINE_PIXELS=4 → line_error=1 after LVAL falls; capture continues.
- Arm while LVAL=1 mid-line → no pixels accepted until LVAL goes low then high; first word is built from the first pixels of the next line.
- write_reset pulsed after 6 pixels → no further writes; state IDLE; all outputs at reset values; a new arm captures cleanly.
- With PACKER_TEST_PATTERN_EN, an 8-pixel frame → writes 32'h03020100 then 32'h07060504 regardless of D.
